// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : onchip_mem_arbiter_if
// Brief   : Two Avalon-MM masters plus the shared single-port RAM slave bus.
// Revision: 1.0 - initial release
// ============================================================================
interface onchip_mem_arbiter_if;
  logic [10:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic        m0_lock;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;

  logic [10:0] m1_address;
  logic [3:0]  m1_byteenable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic        m1_lock;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;

  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  // Arbiter side.
  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  // Requester and RAM side.
  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : onchip_mem_arbiter
// Brief   : Round-robin arbiter with bounded lock sharing one on-chip RAM.
// Revision: 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  onchip_mem_arbiter_if.slave bus
);

  localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

  logic       w_req0;
  logic       w_req1;
  logic       w_keep;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       r_owner;
  logic [3:0] r_hold_cnt;
  logic [1:0] r_rd_pend;

  assign w_req0 = bus.m0_read | bus.m0_write;
  assign w_req1 = bus.m1_read | bus.m1_write;
  assign w_keep = (r_owner ? bus.m1_lock : bus.m0_lock) && (r_hold_cnt < c_max_hold);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_req0 && w_req1) begin
      // Under contention the non-owner wins unless the owner holds a live lock.
      if (w_keep) begin
        w_gnt0 = ~r_owner;
        w_gnt1 = r_owner;
      end else begin
        w_gnt0 = r_owner;
        w_gnt1 = ~r_owner;
      end
    end else begin
      w_gnt0 = w_req0;
      w_gnt1 = w_req1;
    end
  end

  assign bus.m0_waitrequest = w_req0 & ~w_gnt0;
  assign bus.m1_waitrequest = w_req1 & ~w_gnt1;

  assign bus.mem_address    = w_gnt1 ? bus.m1_address    : bus.m0_address;
  assign bus.mem_byteenable = w_gnt1 ? bus.m1_byteenable : bus.m0_byteenable;
  assign bus.mem_writedata  = w_gnt1 ? bus.m1_writedata  : bus.m0_writedata;
  assign bus.mem_chipselect = w_gnt0 | w_gnt1;
  assign bus.mem_write      = w_gnt1 ? bus.m1_write : (w_gnt0 & bus.m0_write);
  assign bus.mem_clken      = 1'b1;

  // RAM output is combinational off a registered address, so data lands one cycle later.
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  assign bus.m0_readdatavalid = r_rd_pend[0];
  assign bus.m1_readdatavalid = r_rd_pend[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= 1'b1;
      r_hold_cnt <= 4'd0;
      r_rd_pend  <= 2'b00;
    end else begin
      r_rd_pend <= {w_gnt1 & bus.m1_read & ~bus.m1_write,
                    w_gnt0 & bus.m0_read & ~bus.m0_write};
      if (w_gnt0 || w_gnt1) begin
        if (w_gnt1 == r_owner) begin
          if (r_hold_cnt < c_max_hold) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end else begin
          r_owner    <= w_gnt1;
          r_hold_cnt <= 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
